// File: rtl/gt_rx_word_align_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gt_rx_word_align_if : raw GT RX word in, word-aligned stream out          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface gt_rx_word_align_if;
  logic [31:0] rxdata;
  logic [3:0]  rxcharisk;
  logic        rx_aligned;
  logic [31:0] data;
  logic [3:0]  charisk;
  logic        valid;
  logic        link_up;
  logic [1:0]  offset;

  modport master (
    output rxdata, rxcharisk, rx_aligned,
    input  data, charisk, valid, link_up, offset
  );

  modport slave (
    input  rxdata, rxcharisk, rx_aligned,
    output data, charisk, valid, link_up, offset
  );
endinterface
`default_nettype wire

// File: rtl/gt_rx_word_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gt_rx_word_align : rotates GT RX byte lanes so K28.5 sits in byte 0,      |
// | qualified by a hunt/verify/lock state machine. Revision 1.0              |
// +--------------------------------------------------------------------------+
module gt_rx_word_align #(
  parameter logic [7:0] COMMA_BYTE = 8'hBC,
  parameter int         LOCK_CNT   = 4,
  parameter int         ERR_CNT    = 3,
  parameter int         TIMEOUT    = 1024
) (
  input  wire logic          rx_clk,
  input  wire logic          rx_rst_n,
  gt_rx_word_align_if.slave  rx
);

  localparam logic [3:0]  LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [3:0]  ERR_MAX  = 4'(ERR_CNT);
  localparam logic [15:0] TO_MAX   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  k, k_nxt;
  logic [3:0]  lock_cnt, lock_cnt_nxt;
  logic [3:0]  err_cnt, err_cnt_nxt;
  logic [15:0] to_cnt, to_cnt_nxt;

  logic [3:0]  hit;
  logic        comma_any;
  logic [1:0]  hit_idx;
  logic [3:0]  lock_inc;
  logic [3:0]  err_inc;
  logic [15:0] to_inc;

  logic [31:0] prev_data;
  logic [3:0]  prev_charisk;
  logic [31:0] aligned_data;
  logic [3:0]  aligned_charisk;

  for (genvar n = 0; n < 4; n++) begin : g_hit
    assign hit[n] = rx.rxcharisk[n] & (rx.rxdata[8*n +: 8] == COMMA_BYTE);
  end

  assign comma_any = |hit;

  // Lowest byte wins when several lanes carry a comma.
  always_comb begin
    hit_idx = 2'd0;
    if (hit[0])      hit_idx = 2'd0;
    else if (hit[1]) hit_idx = 2'd1;
    else if (hit[2]) hit_idx = 2'd2;
    else if (hit[3]) hit_idx = 2'd3;
  end

  assign lock_inc = lock_cnt + 4'd1;
  assign err_inc  = err_cnt + 4'd1;
  assign to_inc   = to_cnt + 16'd1;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state    <= ST_HUNT;
      k        <= 2'd0;
      lock_cnt <= 4'd0;
      err_cnt  <= 4'd0;
      to_cnt   <= 16'd0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      lock_cnt <= lock_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    lock_cnt_nxt = lock_cnt;
    err_cnt_nxt  = err_cnt;
    to_cnt_nxt   = to_cnt;

    // Loss of byte alignment overrides everything, even a comma in the same word.
    if (!rx.rx_aligned) begin
      state_nxt    = ST_HUNT;
      lock_cnt_nxt = 4'd0;
      err_cnt_nxt  = 4'd0;
      to_cnt_nxt   = 16'd0;
    end else begin
      unique case (state)
        ST_HUNT: begin
          if (comma_any) begin
            k_nxt        = hit_idx;
            lock_cnt_nxt = 4'd1;
            err_cnt_nxt  = 4'd0;
            to_cnt_nxt   = 16'd0;
            state_nxt    = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (comma_any) begin
            if (hit_idx == k) begin
              lock_cnt_nxt = lock_inc;
              if (lock_inc == LOCK_MAX) begin
                state_nxt   = ST_LOCKED;
                err_cnt_nxt = 4'd0;
                to_cnt_nxt  = 16'd0;
              end
            end else begin
              k_nxt        = hit_idx;
              lock_cnt_nxt = 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (!comma_any) begin
            to_cnt_nxt = to_inc;
            if (to_inc == TO_MAX) begin
              state_nxt    = ST_HUNT;
              lock_cnt_nxt = 4'd0;
              err_cnt_nxt  = 4'd0;
              to_cnt_nxt   = 16'd0;
            end
          end else if (hit_idx == k) begin
            err_cnt_nxt = 4'd0;
            to_cnt_nxt  = 16'd0;
          end else begin
            err_cnt_nxt = err_inc;
            if (err_inc == ERR_MAX) begin
              state_nxt    = ST_HUNT;
              lock_cnt_nxt = 4'd0;
              err_cnt_nxt  = 4'd0;
              to_cnt_nxt   = 16'd0;
            end
          end
        end
        default: begin
          state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  // Aligned word spans the previous word's upper bytes and the current word's lower bytes.
  always_comb begin
    aligned_data    = prev_data;
    aligned_charisk = prev_charisk;
    unique case (k)
      2'd0: begin
        aligned_data    = prev_data;
        aligned_charisk = prev_charisk;
      end
      2'd1: begin
        aligned_data    = {rx.rxdata[7:0], prev_data[31:8]};
        aligned_charisk = {rx.rxcharisk[0], prev_charisk[3:1]};
      end
      2'd2: begin
        aligned_data    = {rx.rxdata[15:0], prev_data[31:16]};
        aligned_charisk = {rx.rxcharisk[1:0], prev_charisk[3:2]};
      end
      2'd3: begin
        aligned_data    = {rx.rxdata[23:0], prev_data[31:24]};
        aligned_charisk = {rx.rxcharisk[2:0], prev_charisk[3]};
      end
      default: begin
        aligned_data    = prev_data;
        aligned_charisk = prev_charisk;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      prev_data    <= 32'd0;
      prev_charisk <= 4'd0;
      rx.data      <= 32'd0;
      rx.charisk   <= 4'd0;
      rx.valid     <= 1'b0;
      rx.link_up   <= 1'b0;
    end else begin
      prev_data    <= rx.rxdata;
      prev_charisk <= rx.rxcharisk;
      rx.data      <= aligned_data;
      rx.charisk   <= aligned_charisk;
      rx.valid     <= (state == ST_LOCKED);
      rx.link_up   <= (state == ST_LOCKED);
    end
  end

  assign rx.offset = k;

endmodule
`default_nettype wire

// File: tb/tb_gt_rx_word_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gt_rx_word_align : randomized bench with a behavioural alignment model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gt_rx_word_align;

  localparam int LOCK_CNT = 4;
  localparam int ERR_CNT  = 3;
  localparam int TIMEOUT  = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gt_rx_word_align_if bus ();

  gt_rx_word_align #(
    .COMMA_BYTE (8'hBC),
    .LOCK_CNT   (LOCK_CNT),
    .ERR_CNT    (ERR_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .rx_clk   (clk),
    .rx_rst_n (rst_n),
    .rx       (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = hunting, 1 = verifying, 2 = locked
  int          m_mode;
  logic [1:0]  m_k;
  int          m_lock, m_err, m_to;
  logic [31:0] m_prev_d;
  logic [3:0]  m_prev_k;
  logic [31:0] exp_data;
  logic [3:0]  exp_charisk;
  logic        exp_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 2'd0; m_lock = 0; m_err = 0; m_to = 0;
    m_prev_d = 32'd0; m_prev_k = 4'd0;
    exp_data = 32'd0; exp_charisk = 4'd0; exp_valid = 1'b0;
  endtask

  task automatic model_clear_counts();
    m_lock = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] ck, input bit al);
    logic [63:0] cat;
    logic [7:0]  ck8;
    int          hit;
    cat         = {d, m_prev_d} >> (8 * int'(m_k));
    ck8         = {ck, m_prev_k} >> int'(m_k);
    exp_data    = cat[31:0];
    exp_charisk = ck8[3:0];
    exp_valid   = (m_mode == 2);
    hit = -1;
    for (int n = 3; n >= 0; n--)
      if (ck[n] && d[8*n +: 8] == 8'hBC) hit = n;
    if (!al) begin
      m_mode = 0;
      model_clear_counts();
    end else if (m_mode == 0) begin
      if (hit >= 0) begin
        m_k = 2'(hit); m_lock = 1; m_err = 0; m_to = 0;
        m_mode = (LOCK_CNT == 1) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (hit >= 0 && hit == int'(m_k)) begin
        m_lock++;
        if (m_lock == LOCK_CNT) begin m_mode = 2; m_err = 0; m_to = 0; end
      end else if (hit >= 0) begin
        m_k = 2'(hit); m_lock = 1;
      end
    end else begin
      if (hit < 0) begin
        m_to++;
        if (m_to == TIMEOUT) begin m_mode = 0; model_clear_counts(); end
      end else if (hit == int'(m_k)) begin
        m_err = 0; m_to = 0;
      end else begin
        m_err++;
        if (m_err == ERR_CNT) begin m_mode = 0; model_clear_counts(); end
      end
    end
    m_prev_d = d;
    m_prev_k = ck;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "/data"},    bus.data,    exp_data);
    check_val({tag, "/charisk"}, {28'd0, bus.charisk}, {28'd0, exp_charisk});
    check_val({tag, "/valid"},   {31'd0, bus.valid},   {31'd0, exp_valid});
    check_val({tag, "/link_up"}, {31'd0, bus.link_up}, {31'd0, exp_valid});
    check_val({tag, "/offset"},  {30'd0, bus.offset},  {30'd0, m_k});
  endtask

  task automatic apply(input logic [31:0] d, input logic [3:0] ck, input bit al, input string tag);
    bus.rxdata     = d;
    bus.rxcharisk  = ck;
    bus.rx_aligned = al;
    model_step(d, ck, al);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // p: comma lane (-1 none); p2: extra comma lane; junk: a non-comma K char somewhere
  task automatic run_word(input int p, input int p2, input bit al, input bit junk, input string tag);
    logic [31:0] d;
    logic [3:0]  ck;
    int          n;
    d  = $urandom;
    ck = 4'd0;
    if (junk) begin
      n = $urandom_range(0, 3);
      d[8*n +: 8] = 8'hF7;
      ck[n] = 1'b1;
    end
    if (p2 >= 0) begin d[8*p2 +: 8] = 8'hBC; ck[p2] = 1'b1; end
    if (p  >= 0) begin d[8*p  +: 8] = 8'hBC; ck[p]  = 1'b1; end
    apply(d, ck, al, tag);
  endtask

  task automatic to_hunt();
    run_word(-1, -1, 1'b0, 1'b0, "drop");
    run_word(-1, -1, 1'b1, 1'b0, "idle");
  endtask

  task automatic lock_at(input int p);
    for (int i = 0; i < LOCK_CNT; i++) run_word(p, -1, 1'b1, 1'b0, "lock");
    run_word(-1, -1, 1'b1, 1'b0, "lock_settle");
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.rxdata     = 32'd0;
    bus.rxcharisk  = 4'd0;
    bus.rx_aligned = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_word(-1, -1, 1'b1, 1'b0, "idle");

    // Comma at byte 0 every 4th word; link_up follows the 4th comma word by one clock
    for (int i = 0; i < 20; i++) begin
      run_word((i % 4 == 0) ? 0 : -1, -1, 1'b1, 1'b0, "tp1");
      if (i == 12) check_val("tp1_link_pre", {31'd0, bus.link_up}, 32'd0);
      if (i == 13) check_val("tp1_link_up",  {31'd0, bus.link_up}, 32'd1);
    end
    to_hunt();

    // Comma in byte 2
    for (int i = 0; i < 4; i++) begin
      apply(32'h11BC_3322, 4'b0100, 1'b1, "tp2");
      apply(32'h5544_7766, 4'b0000, 1'b1, "tp2");
    end
    check_val("tp2_data",    bus.data, 32'h7766_11BC);
    check_val("tp2_charisk", {28'd0, bus.charisk}, 32'd1);
    check_val("tp2_offset",  {30'd0, bus.offset},  32'd2);
    check_val("tp2_valid",   {31'd0, bus.valid},   32'd1);
    to_hunt();

    // VERIFY restart on a comma at a different lane
    run_word(0, -1, 1'b1, 1'b0, "tp3");
    run_word(0, -1, 1'b1, 1'b0, "tp3");
    run_word(1, -1, 1'b1, 1'b0, "tp3");
    check_val("tp3_offset", {30'd0, bus.offset}, 32'd1);
    for (int i = 0; i < 5; i++) run_word(1, -1, 1'b1, 1'b0, "tp3");
    to_hunt();

    // Wrong-offset commas while locked
    lock_at(0);
    for (int i = 0; i < 3; i++) run_word(3, -1, 1'b1, 1'b0, "tp4_bad3");
    run_word(-1, -1, 1'b1, 1'b0, "tp4_bad3");
    check_val("tp4_dropped", {31'd0, bus.valid}, 32'd0);
    lock_at(0);
    run_word(3, -1, 1'b1, 1'b0, "tp4_bad2");
    run_word(3, -1, 1'b1, 1'b0, "tp4_bad2");
    run_word(0, -1, 1'b1, 1'b0, "tp4_bad2");
    run_word(3, -1, 1'b1, 1'b0, "tp4_bad2");
    run_word(-1, -1, 1'b1, 1'b0, "tp4_bad2");
    check_val("tp4_held", {31'd0, bus.valid}, 32'd1);
    to_hunt();

    // Timeout: comma at clock 1023 rescues, 1024 silent clocks lose lock
    lock_at(2);
    for (int i = 0; i < TIMEOUT - 2; i++) run_word(-1, -1, 1'b1, 1'b0, "tp5_gap");
    run_word(2, -1, 1'b1, 1'b0, "tp5_rescue");
    for (int i = 0; i < TIMEOUT; i++) run_word(-1, -1, 1'b1, 1'b0, "tp5_timeout");
    run_word(-1, -1, 1'b1, 1'b0, "tp5_after");
    check_val("tp5_lost", {31'd0, bus.link_up}, 32'd0);

    // Alignment drop with a valid comma in the same word
    lock_at(1);
    run_word(1, -1, 1'b0, 1'b0, "tp6_drop");
    run_word(1, -1, 1'b1, 1'b0, "tp6_drop");
    check_val("tp6_down", {31'd0, bus.valid}, 32'd0);

    // Asynchronous reset in the middle of a locked stream
    lock_at(3);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("tp6_async_rst");
    #2 rst_n = 1'b1;

    // Randomized segments with multi-comma words, foreign K chars and alignment drops
    for (int seg = 0; seg < 60; seg++) begin
      int period, pos, len;
      period = $urandom_range(1, 5);
      pos    = $urandom_range(0, 3);
      len    = $urandom_range(10, 50);
      for (int i = 0; i < len; i++) begin
        int p, p2;
        bit al, junk;
        p    = (i % period == 0) ? pos : -1;
        p2   = -1;
        if ($urandom_range(0, 9) == 0) p = $urandom_range(0, 3);
        if (p >= 0 && p < 3 && $urandom_range(0, 7) == 0) p2 = $urandom_range(p + 1, 3);
        al   = ($urandom_range(0, 59) != 0);
        junk = ($urandom_range(0, 9) == 0);
        run_word(p, p2, al, junk, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
